// File: rtl/al422_bam_scan_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : al422_bam_scan_sequencer                                        |
// | Purpose  : BAM scan scheduler for the AL422-fed LED panel driver.          |
// |            Per plane: start row-data shifter, pulse the panel latch,       |
// |            update the row address, start the OE processor with the         |
// |            plane's bit index. Shifting of plane N+1 overlaps the OE        |
// |            display of plane N. frame_done lets the FIFO read side rewind.  |
// | Ports    : in_clk, in_nrst (async, active-low)                            |
// |            enable       - run scan (level)                                 |
// |            shift_start  - pulse: shift out next plane                      |
// |            shift_busy   - shifter busy (rises cycle after shift_start)     |
// |            led_latch    - panel latch strobe, LATCH_WIDTH clocks           |
// |            oe_start     - pulse: start OE processor                        |
// |            oe_busy      - OE processor busy (rises cycle after oe_start)   |
// |            bit_counter  - displayed plane index                            |
// |            row_addr     - displayed row address                            |
// |            frame_done   - pulse: last plane of the frame shifted           |
// |            busy         - sequencer not idle                               |
// | Option   : `define AL422_BAM_ROW_SETTLE_EN inserts ROW_SETTLE_CYCLES idle  |
// |            cycles between latch and OE start when the row address changes. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module al422_bam_scan_sequencer #(
   parameter int BAM_BITS          = 8,
   parameter int BITS_IN_COUNTER   = 3,
   parameter int ROW_BITS          = 4,
   parameter int LATCH_WIDTH       = 2,
   parameter int ROW_SETTLE_CYCLES = 4
) (
   input  logic                       in_clk,
   input  logic                       in_nrst,
   input  logic                       enable,
   output logic                       shift_start,
   input  logic                       shift_busy,
   output logic                       led_latch,
   output logic                       oe_start,
   input  logic                       oe_busy,
   output logic [BITS_IN_COUNTER-1:0] bit_counter,
   output logic [ROW_BITS-1:0]        row_addr,
   output logic                       frame_done,
   output logic                       busy
);

   localparam int c_LCNT_W = (LATCH_WIDTH > 1) ? $clog2(LATCH_WIDTH) : 1;
   localparam logic [c_LCNT_W-1:0]        c_LATCH_LAST = c_LCNT_W'(LATCH_WIDTH - 1);
   localparam logic [BITS_IN_COUNTER-1:0] c_BIT_LAST   = BITS_IN_COUNTER'(BAM_BITS - 1);
   localparam logic [ROW_BITS-1:0]        c_ROW_LAST   = {ROW_BITS{1'b1}};

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SHIFT   = 3'd1,
      WAIT_OE = 3'd2,
      LATCH   = 3'd3,
      OE_GO   = 3'd4,
      DRAIN   = 3'd5,
      SETTLE  = 3'd6
   } state_t;

   state_t                       r_state;
   logic [ROW_BITS-1:0]          r_row_s;      // shift index: plane in / next into the shifter
   logic [BITS_IN_COUNTER-1:0]   r_bit_s;
   logic [c_LCNT_W-1:0]          r_latch_cnt;
   logic                         w_last_plane;

   assign w_last_plane = (r_row_s == c_ROW_LAST) && (r_bit_s == c_BIT_LAST);

`ifdef AL422_BAM_ROW_SETTLE_EN
   localparam int c_SCNT_W = (ROW_SETTLE_CYCLES > 1) ? $clog2(ROW_SETTLE_CYCLES) : 1;
   localparam logic [c_SCNT_W-1:0] c_SETTLE_LAST = c_SCNT_W'(ROW_SETTLE_CYCLES - 1);

   logic [c_SCNT_W-1:0] r_settle_cnt;
   logic                r_row_chg;
   logic                w_row_chg;

   // With a one-cycle latch the first and last latch cycles coincide, so the
   // comparison must be taken live instead of from the stored flag.
   assign w_row_chg = (r_latch_cnt == '0) ? (r_row_s != row_addr) : r_row_chg;
`else
   logic w_unused_settle;
   assign w_unused_settle = (ROW_SETTLE_CYCLES != 0);
`endif

   always_ff @(posedge in_clk or negedge in_nrst) begin
      if (!in_nrst) begin
         r_state     <= IDLE;
         r_row_s     <= '0;
         r_bit_s     <= '0;
         r_latch_cnt <= '0;
         shift_start <= 1'b0;
         led_latch   <= 1'b0;
         oe_start    <= 1'b0;
         bit_counter <= '0;
         row_addr    <= '0;
         frame_done  <= 1'b0;
         busy        <= 1'b0;
`ifdef AL422_BAM_ROW_SETTLE_EN
         r_settle_cnt <= '0;
         r_row_chg    <= 1'b0;
`endif
      end else begin
         shift_start <= 1'b0;
         oe_start    <= 1'b0;
         frame_done  <= 1'b0;

         case (r_state)
            IDLE: begin
               r_row_s <= '0;
               r_bit_s <= '0;
               if (enable) begin
                  shift_start <= 1'b1;
                  busy        <= 1'b1;
                  r_state     <= SHIFT;
               end
            end

            // Coming from IDLE the start pulse is still high in this state and
            // the shifter has not yet raised busy; ignore busy until it drops.
            SHIFT: begin
               if (!shift_start && !shift_busy) begin
                  frame_done <= w_last_plane;
                  if (!oe_busy) begin
                     led_latch   <= 1'b1;
                     r_latch_cnt <= '0;
                     r_state     <= LATCH;
                  end else begin
                     r_state <= WAIT_OE;
                  end
               end
            end

            // Shifted data stays in the panel registers until the current
            // plane's display has finished.
            WAIT_OE: begin
               if (!oe_busy) begin
                  led_latch   <= 1'b1;
                  r_latch_cnt <= '0;
                  r_state     <= LATCH;
               end
            end

            LATCH: begin
               if (r_latch_cnt == '0) begin
                  bit_counter <= r_bit_s;
                  row_addr    <= r_row_s;
`ifdef AL422_BAM_ROW_SETTLE_EN
                  r_row_chg   <= (r_row_s != row_addr);
`endif
                  if (r_bit_s == c_BIT_LAST) begin
                     r_bit_s <= '0;
                     r_row_s <= r_row_s + ROW_BITS'(1);
                  end else begin
                     r_bit_s <= r_bit_s + BITS_IN_COUNTER'(1);
                  end
               end
               if (r_latch_cnt == c_LATCH_LAST) begin
                  led_latch <= 1'b0;
`ifdef AL422_BAM_ROW_SETTLE_EN
                  if (w_row_chg) begin
                     r_settle_cnt <= '0;
                     r_state      <= SETTLE;
                  end else begin
                     oe_start    <= 1'b1;
                     shift_start <= enable;
                     r_state     <= OE_GO;
                  end
`else
                  oe_start    <= 1'b1;
                  shift_start <= enable;
                  r_state     <= OE_GO;
`endif
               end else begin
                  r_latch_cnt <= r_latch_cnt + c_LCNT_W'(1);
               end
            end

`ifdef AL422_BAM_ROW_SETTLE_EN
            SETTLE: begin
               if (r_settle_cnt == c_SETTLE_LAST) begin
                  oe_start    <= 1'b1;
                  shift_start <= enable;
                  r_state     <= OE_GO;
               end else begin
                  r_settle_cnt <= r_settle_cnt + c_SCNT_W'(1);
               end
            end
`endif

            // oe_start (and shift_start when running) are high in this cycle;
            // the registered shift_start records whether enable was still set.
            OE_GO: begin
               r_state <= shift_start ? SHIFT : DRAIN;
            end

            DRAIN: begin
               if (!oe_busy) begin
                  r_row_s     <= '0;
                  r_bit_s     <= '0;
                  bit_counter <= '0;
                  row_addr    <= '0;
                  busy        <= 1'b0;
                  r_state     <= IDLE;
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_al422_bam_scan_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_al422_bam_scan_sequencer                                     |
// | Purpose  : Self-checking bench for al422_bam_scan_sequencer with shifter   |
// |            and OE processor behavioural models.                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_al422_bam_scan_sequencer;

   localparam int BAM_BITS          = 3;
   localparam int BITS_IN_COUNTER   = 3;
   localparam int ROW_BITS          = 1;
   localparam int LATCH_WIDTH       = 2;
   localparam int ROW_SETTLE_CYCLES = 4;
   localparam int ROWS              = 1 << ROW_BITS;
   localparam int PLANES            = BAM_BITS * ROWS;
`ifdef AL422_BAM_ROW_SETTLE_EN
   localparam int SETTLE_EXTRA = ROW_SETTLE_CYCLES;
`else
   localparam int SETTLE_EXTRA = 0;
`endif

   logic                       in_clk = 1'b0;
   logic                       in_nrst;
   logic                       enable;
   logic                       shift_start;
   logic                       shift_busy;
   logic                       led_latch;
   logic                       oe_start;
   logic                       oe_busy;
   logic [BITS_IN_COUNTER-1:0] bit_counter;
   logic [ROW_BITS-1:0]        row_addr;
   logic                       frame_done;
   logic                       busy;

   int checks = 0;
   int errors = 0;

   al422_bam_scan_sequencer #(
      .BAM_BITS          (BAM_BITS),
      .BITS_IN_COUNTER   (BITS_IN_COUNTER),
      .ROW_BITS          (ROW_BITS),
      .LATCH_WIDTH       (LATCH_WIDTH),
      .ROW_SETTLE_CYCLES (ROW_SETTLE_CYCLES)
   ) dut (
      .in_clk      (in_clk),
      .in_nrst     (in_nrst),
      .enable      (enable),
      .shift_start (shift_start),
      .shift_busy  (shift_busy),
      .led_latch   (led_latch),
      .oe_start    (oe_start),
      .oe_busy     (oe_busy),
      .bit_counter (bit_counter),
      .row_addr    (row_addr),
      .frame_done  (frame_done),
      .busy        (busy)
   );

   always #5 in_clk = ~in_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- peripheral models ----------------
   int shift_len = 6;
   int oe_base   = 4;
   int sh_cnt;
   int oe_cnt;

   always @(posedge in_clk or negedge in_nrst) begin
      if (!in_nrst) begin
         sh_cnt     <= 0;
         shift_busy <= 1'b0;
      end else if (shift_start) begin
         sh_cnt     <= shift_len;
         shift_busy <= 1'b1;
      end else if (sh_cnt > 1) begin
         sh_cnt <= sh_cnt - 1;
      end else begin
         sh_cnt     <= 0;
         shift_busy <= 1'b0;
      end
   end

   always @(posedge in_clk or negedge in_nrst) begin
      if (!in_nrst) begin
         oe_cnt  <= 0;
         oe_busy <= 1'b0;
      end else if (oe_start) begin
         oe_cnt  <= oe_base + (1 << bit_counter);
         oe_busy <= 1'b1;
      end else if (oe_cnt > 1) begin
         oe_cnt <= oe_cnt - 1;
      end else begin
         oe_cnt  <= 0;
         oe_busy <= 1'b0;
      end
   end

   // ---------------- reference monitor ----------------
   // Plane n after a (re)start is displayed as row (n/BAM_BITS)%ROWS,
   // bit n%BAM_BITS; a frame ends with every PLANES-th shifted plane.
   int cyc = 0;
   int n_disp, n_shift, frames, prev_row;
   int oe_total = 0, shift_total = 0, frames_total = 0, wait_oe_seen = 0;
   int last_row, last_bit, latch_run, t_done;
   bit pend, pend_idle, prev_sb;

   initial begin
      int exp_row, exp_bit;
      n_disp = 0; n_shift = 0; frames = 0; prev_row = 0;
      latch_run = 0; pend = 0; pend_idle = 0; prev_sb = 0; t_done = 0;
      last_row = 0; last_bit = 0;
      forever begin
         @(negedge in_clk);
         cyc++;
         if (!in_nrst || !busy) begin
            n_disp = 0; n_shift = 0; frames = 0; prev_row = 0; pend = 0;
         end
         if (!in_nrst) begin
            latch_run = 0;
            prev_sb   = 0;
         end else begin
            if (shift_start) begin
               n_shift++;
               shift_total++;
            end
            if (frame_done) begin
               chk("frame_done_plane", (n_shift - 1) % PLANES, PLANES - 1);
               frames++;
               frames_total++;
            end
            if (led_latch) begin
               chk("latch_while_oe_busy", 32'(oe_busy), 0);
               latch_run++;
            end else if (latch_run != 0) begin
               chk("latch_width", latch_run, LATCH_WIDTH);
               latch_run = 0;
            end
            if (prev_sb && !shift_busy) begin
               pend      = 1;
               pend_idle = !oe_busy;
               t_done    = cyc;
               if (oe_busy) wait_oe_seen++;
            end
            if (oe_start) begin
               exp_row = (n_disp / BAM_BITS) % ROWS;
               exp_bit = n_disp % BAM_BITS;
               chk("oe_row", 32'(row_addr), exp_row);
               chk("oe_bit", 32'(bit_counter), exp_bit);
               chk("oe_busy_out", 32'(busy), 1);
               if (pend && pend_idle)
                  chk("oe_latency", cyc - t_done,
                      LATCH_WIDTH + 1 + ((exp_row != prev_row) ? SETTLE_EXTRA : 0));
               if (n_disp % PLANES == PLANES - 1)
                  chk("frames_at_last_plane", frames, n_disp / PLANES + 1);
               pend     = 0;
               prev_row = exp_row;
               last_row = int'(row_addr);
               last_bit = int'(bit_counter);
               n_disp++;
               oe_total++;
            end
            prev_sb = shift_busy;
         end
      end
   end

   // ---------------- bounded waits ----------------
   task automatic wait_oe(input int budget, input string tag);
      for (int k = 0; k < budget; k++) begin
         @(negedge in_clk);
         if (oe_start) break;
      end
      chk(tag, 32'(oe_start), 1);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      for (int k = 0; k < budget; k++) begin
         @(negedge in_clk);
         if (!busy) break;
      end
      chk(tag, 32'(busy), 0);
   endtask

   task automatic wait_sig(input int budget, input int which, input bit val, input string tag);
      logic s;
      s = ~val;
      for (int k = 0; k < budget; k++) begin
         @(negedge in_clk);
         case (which)
            0:       s = shift_busy;
            1:       s = shift_start;
            default: s = led_latch & row_addr[0];
         endcase
         if (s == val) break;
      end
      chk(tag, 32'(s), 32'(val));
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int s0, o0;
      in_nrst = 1'b0;
      enable  = 1'b0;
      repeat (3) @(negedge in_clk);
      chk("rst_shift_start", 32'(shift_start), 0);
      chk("rst_led_latch",   32'(led_latch),   0);
      chk("rst_oe_start",    32'(oe_start),    0);
      chk("rst_bit_counter", 32'(bit_counter), 0);
      chk("rst_row_addr",    32'(row_addr),    0);
      chk("rst_frame_done",  32'(frame_done),  0);
      chk("rst_busy",        32'(busy),        0);
      in_nrst = 1'b1;
      @(negedge in_clk);

      // 1: first plane timing
      enable = 1'b1;
      @(posedge in_clk); #1;
      chk("t1_shift_start_first", 32'(shift_start), 1);
      chk("t1_busy", 32'(busy), 1);
      wait_sig(50, 0, 1'b1, "t1_shift_busy_rise");
      wait_sig(50, 0, 1'b0, "t1_shift_busy_fall");
      @(negedge in_clk);
      chk("t1_latch_cyc1", 32'(led_latch), 1);
      @(negedge in_clk);
      chk("t1_latch_cyc2", 32'(led_latch), 1);
      @(negedge in_clk);
      chk("t1_latch_low", 32'(led_latch), 0);
      chk("t1_oe_start", 32'(oe_start), 1);
      chk("t1_bit", 32'(bit_counter), 0);
      chk("t1_row", 32'(row_addr), 0);
      chk("t1_shift_with_oe", 32'(shift_start), 1);

      // 2: a frame and its wrap
      for (int i = 1; i <= 12; i++) begin
         wait_oe(400, "t2_oe_start");
         chk("t2_row", 32'(row_addr), (i / BAM_BITS) % ROWS);
         chk("t2_bit", 32'(bit_counter), i % BAM_BITS);
      end
      chk("t2_frames", frames_total, 2);

      // 3: display longer than shift
      oe_base = 20;
      s0 = wait_oe_seen;
      for (int i = 0; i < 6; i++) wait_oe(800, "t3_oe_start");
      chk("t3_wait_oe_seen", 32'(wait_oe_seen > s0), 1);
      oe_base = 4;

      // 4: drop enable while plane (0,1) is shifting
      enable = 1'b0;
      wait_idle(1000, "t4_pre_idle");
      enable = 1'b1;
      wait_sig(50, 1, 1'b1, "t4_shift0");
      wait_sig(400, 1, 1'b1, "t4_shift1");
      repeat ($urandom_range(1, 3)) @(negedge in_clk);
      enable = 1'b0;
      s0 = shift_total;
      o0 = oe_total;
      wait_idle(1000, "t4_idle");
      chk("t4_no_more_shift", shift_total, s0);
      chk("t4_oe_count", oe_total, o0 + 1);
      chk("t4_last_row", last_row, 0);
      chk("t4_last_bit", last_bit, 1);
      chk("t4_oe_busy_low", 32'(oe_busy), 0);
      enable = 1'b1;
      wait_oe(200, "t4_restart_oe");
      chk("t4_restart_row", 32'(row_addr), 0);
      chk("t4_restart_bit", 32'(bit_counter), 0);

      // 5: asynchronous reset during a row-1 latch
      wait_sig(1000, 2, 1'b1, "t5_find_latch");
      #2 in_nrst = 1'b0;
      #1;
      chk("t5_latch_async", 32'(led_latch), 0);
      chk("t5_busy_async", 32'(busy), 0);
      chk("t5_row_async", 32'(row_addr), 0);
      repeat (2) @(negedge in_clk);
      in_nrst = 1'b1;
      wait_oe(200, "t5_restart_oe");
      chk("t5_restart_row", 32'(row_addr), 0);
      chk("t5_restart_bit", 32'(bit_counter), 0);

      // random timing and enable drops, checked by the monitor
      for (int r = 0; r < 6; r++) begin
         shift_len = $urandom_range(2, 9);
         oe_base   = $urandom_range(1, 25);
         repeat ($urandom_range(3, 14)) wait_oe(1500, "rnd_oe_start");
         repeat ($urandom_range(0, 8)) @(negedge in_clk);
         enable = 1'b0;
         wait_idle(2000, "rnd_idle");
         chk("rnd_oe_idle", 32'(oe_busy), 0);
         enable = 1'b1;
      end

      enable = 1'b0;
      wait_idle(2000, "end_idle");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
